ssemi_cic_decimator: RTL and testbench

- Configurable N-stage CIC (Hogenauer) decimator with runtime decimation rate R and output shift.
- Sits directly upstream of the halfband filter: takes modulator-rate samples and produces reduced-rate words that feed the halfband filter's i_data/i_valid.
- Honours halfband backpressure via i_ready.
- Reports overflow/saturation and overrun status.

---
 rtl/ssemi_cic_decimator.sv | 205 ++++++++++++++++++++
 tb/tb_ssemi_cic_decimator.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssemi_cic_decimator.sv
// ---------------------------------------------------------------------------
// ssemi_cic_decimator
//
// N-stage CIC (Hogenauer) decimator with runtime rate R and output shift.
// Accepts modulator-rate samples and delivers one saturated, shifted word
// every R accepted samples to the downstream halfband filter.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_enable              block enable; low clears all state synchronously
//   i_cfg_load            one-cycle pulse: capture i_decim_rate / i_out_shift
//   i_decim_rate          requested R (clamped to 2..MAX_DECIM_RATE)
//   i_out_shift           arithmetic right shift applied to the comb output
//   i_valid, i_data       input sample stream (signed)
//   o_ready               equals i_enable
//   o_data, o_valid       decimated output, held until o_valid && i_ready
//   i_ready               downstream ready
//   o_overflow/underflow  one-cycle pulses: output saturated high / low
//   o_overrun             sticky: an unconsumed output was overwritten
//   o_cfg_error           sticky: a loaded rate was clamped
//   o_busy                a sample has been accepted since the last clear
// ---------------------------------------------------------------------------
module ssemi_cic_decimator #(
   parameter int NUM_STAGES        = 5,
   parameter int MAX_DECIM_RATE    = 64,
   parameter int INPUT_DATA_WIDTH  = 16,
   parameter int OUTPUT_DATA_WIDTH = 24,
   parameter int RATE_WIDTH        = 9
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_enable,
   input  logic                                i_cfg_load,
   input  logic [RATE_WIDTH-1:0]               i_decim_rate,
   input  logic [5:0]                          i_out_shift,
   input  logic                                i_valid,
   input  logic signed [INPUT_DATA_WIDTH-1:0]  i_data,
   output logic                                o_ready,
   output logic signed [OUTPUT_DATA_WIDTH-1:0] o_data,
   output logic                                o_valid,
   input  logic                                i_ready,
   output logic                                o_overflow,
   output logic                                o_underflow,
   output logic                                o_overrun,
   output logic                                o_cfg_error,
   output logic                                o_busy
);

   localparam int RATE_BITS = $clog2(MAX_DECIM_RATE);
   localparam int W         = INPUT_DATA_WIDTH + NUM_STAGES * RATE_BITS;
   localparam int OW        = OUTPUT_DATA_WIDTH;

   localparam logic [RATE_WIDTH-1:0] MAX_RATE      = RATE_WIDTH'(MAX_DECIM_RATE);
   localparam logic [RATE_WIDTH-1:0] MIN_RATE      = RATE_WIDTH'(2);
   localparam logic [5:0]            DEFAULT_SHIFT =
      6'(NUM_STAGES * RATE_BITS - (OUTPUT_DATA_WIDTH - INPUT_DATA_WIDTH));

   localparam logic signed [W-1:0] OUT_MAX = {{(W-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [W-1:0] OUT_MIN = {{(W-OW+1){1'b1}}, {(OW-1){1'b0}}};

   // Shadow configuration
   logic [RATE_WIDTH-1:0] rate_q;
   logic [5:0]            shift_q;

   // Datapath state
   logic signed [W-1:0]   integ  [NUM_STAGES];
   logic signed [W-1:0]   comb_d [NUM_STAGES];
   logic [RATE_WIDTH-1:0] phase;

   // Combinational comb chain and output stage
   logic signed [W-1:0]   comb_in [NUM_STAGES];
   logic signed [W-1:0]   comb_out;
   logic signed [W-1:0]   comb_shift;
   logic signed [W-1:0]   data_ext;
   logic [RATE_WIDTH-1:0] rate_clamped;
   logic                  rate_bad;
   logic                  accept;
   logic                  strobe;
   logic                  sat_hi;
   logic                  sat_lo;
   logic [OW-1:0]         sat_data;

   assign o_ready = i_enable;

   // A sample arriving with a config load is dropped: the load restarts the filter.
   assign accept = i_valid && i_enable && !i_cfg_load;
   assign strobe = accept && (phase == rate_q - RATE_WIDTH'(1));

   assign data_ext = {{(W-INPUT_DATA_WIDTH){i_data[INPUT_DATA_WIDTH-1]}}, i_data};

   assign rate_bad     = (i_decim_rate < MIN_RATE) || (i_decim_rate > MAX_RATE);
   assign rate_clamped = (i_decim_rate < MIN_RATE) ? MIN_RATE :
                         (i_decim_rate > MAX_RATE) ? MAX_RATE : i_decim_rate;

   // Comb chain evaluated from the registered last integrator, before this
   // cycle's integrator update. Subtraction wraps modulo 2^W by design.
   always_comb begin
      logic signed [W-1:0] acc;
      // NOTE: every variable in a combinational block is assigned on every
      // path before use; a missing default would infer a latch.
      acc = integ[NUM_STAGES-1];
      for (int k = 0; k < NUM_STAGES; k++) begin
         comb_in[k] = acc;
         acc        = acc - comb_d[k];
      end
      comb_out = acc;
   end

   assign comb_shift = comb_out >>> shift_q;
   assign sat_hi     = comb_shift > OUT_MAX;
   assign sat_lo     = comb_shift < OUT_MIN;
   assign sat_data   = sat_hi ? {1'b0, {(OW-1){1'b1}}} :
                       sat_lo ? {1'b1, {(OW-1){1'b0}}} : comb_shift[OW-1:0];

   // Shadow configuration survives i_enable low; only reset restores defaults.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rate_q  <= MAX_RATE;
         shift_q <= DEFAULT_SHIFT;
      end else if (i_cfg_load) begin
         rate_q  <= rate_clamped;
         shift_q <= i_out_shift;
      end
   end

   // Integrators, comb delays and phase counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: these register arrays are reset because clearing them is part
         // of the filter's function; they are flops, not a RAM.
         for (int k = 0; k < NUM_STAGES; k++) begin
            integ[k]  <= '0;
            comb_d[k] <= '0;
         end
         phase <= '0;
      end else if (!i_enable || i_cfg_load) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            integ[k]  <= '0;
            comb_d[k] <= '0;
         end
         phase <= '0;
      end else if (accept) begin
         // NOTE: non-blocking assignment makes each stage add the previous
         // register value of its predecessor, giving the pipelined form.
         integ[0] <= integ[0] + data_ext;
         for (int k = 1; k < NUM_STAGES; k++) begin
            integ[k] <= integ[k] + integ[k-1];
         end
         if (strobe) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
               comb_d[k] <= comb_in[k];
            end
            phase <= '0;
         end else begin
            phase <= phase + RATE_WIDTH'(1);
         end
      end
   end

   // Output register, handshake and status
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
         o_overrun   <= 1'b0;
         o_cfg_error <= 1'b0;
         o_busy      <= 1'b0;
      end else if (!i_enable) begin
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
         o_overrun   <= 1'b0;
         o_cfg_error <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
         if (accept) begin
            o_busy <= 1'b1;
         end
         if (i_cfg_load) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
            if (rate_bad) begin
               o_cfg_error <= 1'b1;
            end
         end else if (strobe) begin
            o_data      <= sat_data;
            o_valid     <= 1'b1;
            o_overflow  <= sat_hi;
            o_underflow <= sat_lo;
            // Overwriting a word the consumer has not taken this cycle.
            if (o_valid && !i_ready) begin
               o_overrun <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ssemi_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_ssemi_cic_decimator
//
// Self-checking bench for ssemi_cic_decimator at default parameters.
// A behavioural CIC model pushes each expected output to a queue when the
// R-th sample is driven; a negedge monitor pops and compares on handshake.
// A table of DC vectors also carries hand-derived settled values.
// ---------------------------------------------------------------------------
module tb_ssemi_cic_decimator;

   localparam int N    = 5;
   localparam int MAXR = 64;
   localparam int IW   = 16;
   localparam int OW   = 24;
   localparam int W    = IW + N * 6;
   localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
   localparam longint OMIN = -(64'sd1 <<< (OW - 1));

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_enable;
   logic          i_cfg_load;
   logic [8:0]    i_decim_rate;
   logic [5:0]    i_out_shift;
   logic          i_valid;
   logic [IW-1:0] i_data;
   logic          o_ready;
   logic [OW-1:0] o_data;
   logic          o_valid;
   logic          i_ready;
   logic          o_overflow;
   logic          o_underflow;
   logic          o_overrun;
   logic          o_cfg_error;
   logic          o_busy;

   ssemi_cic_decimator dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_enable     (i_enable),
      .i_cfg_load   (i_cfg_load),
      .i_decim_rate (i_decim_rate),
      .i_out_shift  (i_out_shift),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .o_ready      (o_ready),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_overflow   (o_overflow),
      .o_underflow  (o_underflow),
      .o_overrun    (o_overrun),
      .o_cfg_error  (o_cfg_error),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [OW-1:0] data;
      bit            ovf;
      bit            unf;
   } exp_t;

   typedef struct {
      int            rate;
      int            shift;
      int            x;
      int            n_samp;
      logic [OW-1:0] settled;
      bit            ovf;
      bit            unf;
   } vec_t;

   exp_t   sb_q[$];
   exp_t   mon_e;
   int     n_checks = 0;
   int     n_pass   = 0;
   int     out_idx  = 0;
   bit     mon_en   = 1'b1;
   bit     settle_en = 1'b0;
   vec_t   cur_vec;

   // Reference model state
   longint m_int [N];
   longint m_dly [N];
   int     m_phase;
   int     m_rate;
   int     m_shift;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic longint wrapw(input longint v);
      return (v <<< (64 - W)) >>> (64 - W);
   endfunction

   function automatic int clamp_rate(input int r);
      return (r < 2) ? 2 : (r > MAXR) ? MAXR : r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         m_int[k] = 0;
         m_dly[k] = 0;
      end
      m_phase = 0;
   endtask

   task automatic model_accept(input int x);
      longint c;
      longint prev;
      longint y;
      exp_t   e;
      if (m_phase == m_rate - 1) begin
         c = m_int[N-1];
         for (int k = 0; k < N; k++) begin
            prev     = c;
            c        = wrapw(c - m_dly[k]);
            m_dly[k] = prev;
         end
         y = c >>> m_shift;
         e.ovf  = (y > OMAX);
         e.unf  = (y < OMIN);
         e.data = e.ovf ? 24'h7FFFFF : e.unf ? 24'h800000 : OW'(y);
         sb_q.push_back(e);
      end
      for (int k = N - 1; k >= 1; k--) m_int[k] = wrapw(m_int[k] + m_int[k-1]);
      m_int[0] = wrapw(m_int[0] + longint'(x));
      m_phase  = (m_phase == m_rate - 1) ? 0 : m_phase + 1;
   endtask

   // A sample driven alongside the load must be dropped by the DUT.
   task automatic cfg_load(input int rate, input int shift);
      i_cfg_load   = 1'b1;
      i_decim_rate = 9'(rate);
      i_out_shift  = 6'(shift);
      i_valid      = 1'b1;
      i_data       = 16'h1234;
      @(posedge i_clk); #1;
      i_cfg_load = 1'b0;
      i_valid    = 1'b0;
      model_clear();
      m_rate  = clamp_rate(rate);
      m_shift = shift;
      sb_q.delete();
      out_idx = 0;
   endtask

   task automatic send_sample(input int x);
      i_valid = 1'b1;
      i_data  = 16'(x);
      model_accept(x);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Monitor: compares every handshake against the scoreboard
   always @(negedge i_clk) begin
      if (mon_en) begin
         if (!o_valid) check("flags_idle", {o_overflow, o_underflow}, 2'b00);
         if (o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_output", o_valid, 1'b0);
            end else begin
               mon_e = sb_q.pop_front();
               check("out_data", o_data, mon_e.data);
               check("out_ovf", o_overflow, mon_e.ovf);
               check("out_unf", o_underflow, mon_e.unf);
               if (settle_en && out_idx >= N) begin
                  check("settled_data", o_data, cur_vec.settled);
                  check("settled_ovf", o_overflow, cur_vec.ovf);
                  check("settled_unf", o_underflow, cur_vec.unf);
               end
               out_idx++;
            end
         end
      end
   end

   vec_t vecs [7];

   initial begin
      //          rate shift      x  n_samp settled       ovf unf
      vecs[0] = '{   4,   10,   100,    40, 24'd100,      0,  0};
      vecs[1] = '{  64,   22, -32768, 2000, 24'h800000,   0,  0};
      vecs[2] = '{  64,    0,  32767,  576, 24'h7FFFFF,   1,  0};
      vecs[3] = '{  64,    0, -32768,  576, 24'h800000,   0,  1};
      vecs[4] = '{   8,   15,  -200,    72, 24'hFFFF38,   0,  0};
      vecs[5] = '{   2,    0,     5,    20, 24'd160,      0,  0};
      vecs[6] = '{  16,   13,   -77,   144, 24'hFFD980,   0,  0};

      i_rst_n      = 1'b0;
      i_enable     = 1'b1;
      i_cfg_load   = 1'b0;
      i_decim_rate = '0;
      i_out_shift  = '0;
      i_valid      = 1'b0;
      i_data       = '0;
      i_ready      = 1'b1;

      // Reset state
      idle(3);
      check("rst_data", o_data, 24'd0);
      check("rst_valid", o_valid, 1'b0);
      check("rst_ovf", o_overflow, 1'b0);
      check("rst_unf", o_underflow, 1'b0);
      check("rst_overrun", o_overrun, 1'b0);
      check("rst_cfg_error", o_cfg_error, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_ready", o_ready, 1'b1);
      i_rst_n = 1'b1;
      model_clear();
      m_rate  = MAXR;
      m_shift = 22;
      idle(1);

      // DC vectors
      for (int v = 0; v < 7; v++) begin
         cur_vec = vecs[v];
         cfg_load(cur_vec.rate, cur_vec.shift);
         settle_en = 1'b1;
         for (int s = 0; s < cur_vec.n_samp; s++) send_sample(cur_vec.x);
         idle(3);
         check("queue_drained", 64'(sb_q.size()), 64'd0);
         check("output_count", 64'(out_idx), 64'(cur_vec.n_samp / cur_vec.rate));
         settle_en = 1'b0;
      end
      check("busy_after_samples", o_busy, 1'b1);

      // Backpressure: two strobes while the consumer stalls
      cfg_load(4, 10);
      mon_en  = 1'b0;
      i_ready = 1'b0;
      for (int i = 0; i < 9; i++) send_sample(1000 + 37 * i);
      check("bp_valid_held", o_valid, 1'b1);
      check("bp_data_second", o_data, sb_q[1].data);
      check("bp_overrun", o_overrun, 1'b1);
      i_ready = 1'b1;
      idle(1);
      check("bp_valid_drop", o_valid, 1'b0);
      check("bp_overrun_sticky", o_overrun, 1'b1);
      cfg_load(4, 10);
      check("bp_overrun_cleared", o_overrun, 1'b0);

      // Strobe coinciding with a handshake: back-to-back, no overrun
      cfg_load(2, 0);
      i_ready = 1'b0;
      send_sample(300);
      send_sample(-500);
      check("co_valid", o_valid, 1'b1);
      send_sample(700);
      i_ready = 1'b1;
      send_sample(-900);
      check("co_valid_b2b", o_valid, 1'b1);
      check("co_data", o_data, sb_q[1].data);
      check("co_no_overrun", o_overrun, 1'b0);
      idle(1);
      check("co_valid_drop", o_valid, 1'b0);
      sb_q.delete();
      mon_en = 1'b1;

      // Config clamp low: rate 1 behaves as 2
      cfg_load(1, 0);
      check("clamp_lo_err", o_cfg_error, 1'b1);
      send_sample(10);
      check("clamp_lo_no_out_1", o_valid, 1'b0);
      send_sample(10);
      check("clamp_lo_out_2", o_valid, 1'b1);
      idle(2);

      // Load clears a pending output; clamp high: rate 300 behaves as 64
      mon_en  = 1'b0;
      i_ready = 1'b0;
      send_sample(10);
      send_sample(10);
      check("clamp_pending_valid", o_valid, 1'b1);
      cfg_load(300, 22);
      check("load_clears_valid", o_valid, 1'b0);
      check("clamp_hi_err", o_cfg_error, 1'b1);
      i_ready = 1'b1;
      mon_en  = 1'b1;
      for (int s = 0; s < 63; s++) send_sample(50);
      check("clamp_hi_no_early", o_valid, 1'b0);
      send_sample(50);
      check("clamp_hi_strobe64", o_valid, 1'b1);
      idle(2);

      // Enable low clears status but keeps the shadow config
      i_enable = 1'b0;
      idle(1);
      check("dis_ready", o_ready, 1'b0);
      check("dis_busy", o_busy, 1'b0);
      check("dis_cfg_error", o_cfg_error, 1'b0);
      check("dis_valid", o_valid, 1'b0);
      i_enable = 1'b1;
      model_clear();
      idle(1);

      // Reset mid-stream with a held output and nonzero integrators
      cfg_load(4, 10);
      mon_en  = 1'b0;
      i_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_sample(100);
      check("mid_valid_before", o_valid, 1'b1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_data", o_data, 24'd0);
      check("mid_rst_valid", o_valid, 1'b0);
      check("mid_rst_overrun", o_overrun, 1'b0);
      check("mid_rst_flags", {o_overflow, o_underflow, o_cfg_error, o_busy}, 4'b0000);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      model_clear();
      m_rate  = MAXR;
      m_shift = 22;
      sb_q.delete();
      out_idx = 0;
      i_ready = 1'b1;
      mon_en  = 1'b1;
      for (int s = 0; s < 63; s++) send_sample(100);
      check("post_rst_no_early", o_valid, 1'b0);
      send_sample(100);
      check("post_rst_strobe", o_valid, 1'b1);
      idle(2);
      check("post_rst_count", 64'(out_idx), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
